// File: rtl/debug_cmd_pkg.sv
// Shared defaults, queue entry layout and edge-detect helper for the JTAG debug
// command synchroniser.
package debug_cmd_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int SYNC_STAGES_DEF = 3;
  localparam int CMD_DEPTH_DEF   = 2;

  // Queue entry: shift-register data in the upper bits, instruction below it.
  typedef struct packed {
    logic [SR_W_DEF-1:0] sr;
    logic [IR_W_DEF-1:0] ir;
  } cmd_entry_t;

  function automatic logic rise_det(input logic cur, input logic prev, input logic armed);
    return cur & ~prev & armed;
  endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Small power-of-two command queue with combinational head read.
// Push to a full queue is accepted only when a pop happens in the same cycle.
module debug_cmd_fifo
  import debug_cmd_pkg::*;
#(
  parameter int W     = SR_W_DEF + IR_W_DEF,
  parameter int DEPTH = CMD_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/debug_cmd_sync.sv
// Brings JTAG update-DR/update-IR levels into the system clock domain, queues
// captured commands and issues them as one-cycle per-channel action strobes.
module debug_cmd_sync
  import debug_cmd_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int ACT_BIT     = SR_W - 3,
  parameter int CMD_DEPTH   = CMD_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [SR_W-1:0]      sr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 vs_udr,
  input  logic                 vs_uir,
  input  logic                 cmd_ready,
  input  logic                 overflow_clr,
  output logic [SR_W-1:0]      jdo,
  output logic [(2**IR_W)-1:0] take_action,
  output logic [(2**IR_W)-1:0] take_no_action,
  output logic                 uir_pulse,
  output logic                 cmd_pending,
  output logic                 overflow
);

  localparam int NCH = 2**IR_W;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q, fill_q;
  logic                   udr_prev_q, uir_prev_q;
  logic                   udr_armed_q, udr_armed_d;
  logic                   uir_armed_q, uir_armed_d;
  logic                   udr_lvl, uir_lvl, chain_valid;
  logic                   udr_det, uir_det;

  logic [SR_W+IR_W-1:0]   fifo_dout;
  logic                   fifo_full, fifo_empty, pop;
  logic [SR_W-1:0]        ent_sr;
  logic [IR_W-1:0]        ent_ir;

  logic [SR_W-1:0]        jdo_q, jdo_d;
  logic [NCH-1:0]         act_q, act_d, nact_q, nact_d;
  logic                   uir_pulse_q, uir_pulse_d;
  logic                   ovf_q, ovf_d, ovf_set;

  assign udr_lvl     = udr_sync_q[SYNC_STAGES-1];
  assign uir_lvl     = uir_sync_q[SYNC_STAGES-1];
  assign chain_valid = fill_q[SYNC_STAGES-1];

  // A level already high at reset release must be seen low once before it can fire.
  assign udr_armed_d = udr_armed_q | (chain_valid & ~udr_lvl);
  assign uir_armed_d = uir_armed_q | (chain_valid & ~uir_lvl);
  assign udr_det     = rise_det(udr_lvl, udr_prev_q, udr_armed_q);
  assign uir_det     = rise_det(uir_lvl, uir_prev_q, uir_armed_q);

  debug_cmd_fifo #(
    .W     (SR_W + IR_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (udr_det),
    .pop     (pop),
    .din     ({sr, ir_in}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_pending = ~fifo_empty;
  assign pop         = cmd_pending & cmd_ready;
  assign ent_sr      = fifo_dout[SR_W+IR_W-1:IR_W];
  assign ent_ir      = fifo_dout[IR_W-1:0];
  assign ovf_set     = udr_det & fifo_full & ~pop;

  always_comb begin
    act_d       = '0;
    nact_d      = '0;
    jdo_d       = jdo_q;
    uir_pulse_d = uir_det;
    if (pop) begin
      jdo_d = ent_sr;
      if (ent_sr[ACT_BIT]) begin
        act_d[ent_ir] = 1'b1;
      end else begin
        nact_d[ent_ir] = 1'b1;
      end
    end else begin
      jdo_d = jdo_q;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      fill_q      <= '0;
      udr_prev_q  <= 1'b0;
      uir_prev_q  <= 1'b0;
      udr_armed_q <= 1'b0;
      uir_armed_q <= 1'b0;
      jdo_q       <= '0;
      act_q       <= '0;
      nact_q      <= '0;
      uir_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      udr_prev_q  <= udr_lvl;
      uir_prev_q  <= uir_lvl;
      udr_armed_q <= udr_armed_d;
      uir_armed_q <= uir_armed_d;
      jdo_q       <= jdo_d;
      act_q       <= act_d;
      nact_q      <= nact_d;
      uir_pulse_q <= uir_pulse_d;
      ovf_q       <= ovf_d;
    end
  end

  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = nact_q;
  assign uir_pulse      = uir_pulse_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_debug_cmd_sync.sv
// Self-checking bench for debug_cmd_sync: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_debug_cmd_sync;
  import debug_cmd_pkg::*;

  localparam int SR_W    = 38;
  localparam int IR_W    = 2;
  localparam int NCH     = 4;
  localparam int SYNC    = 3;
  localparam int ACT_BIT = SR_W - 3;
  localparam int DEPTH   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [SR_W-1:0] sr = '0;
  logic [IR_W-1:0] ir_in = '0;
  logic            vs_udr = 1'b0, vs_uir = 1'b0, cmd_ready = 1'b1, overflow_clr = 1'b0;
  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action, take_no_action;
  logic            uir_pulse, cmd_pending, overflow;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  debug_cmd_sync #(
    .SR_W(SR_W), .IR_W(IR_W), .SYNC_STAGES(SYNC), .ACT_BIT(ACT_BIT), .CMD_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .cmd_ready(cmd_ready), .overflow_clr(overflow_clr), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .uir_pulse(uir_pulse), .cmd_pending(cmd_pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe / uir_pulse monitor, sampled away from the active edge.
  typedef struct { int c; logic [NCH-1:0] ta; logic [NCH-1:0] tna; } strobe_t;
  strobe_t obs[$];
  int      uir_obs[$];

  always @(negedge clk) begin
    if ((take_action | take_no_action) != '0) begin
      chk("strobe_onehot", 64'($countones({take_action, take_no_action})), 64'd1);
      obs.push_back('{cyc, take_action, take_no_action});
    end
    if (uir_pulse) uir_obs.push_back(cyc);
  end

  task automatic send(input logic [SR_W-1:0] d, input logic [IR_W-1:0] i);
    sr = d; ir_in = i; vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(5);
  endtask

  typedef struct { logic [SR_W-1:0] sr; logic [IR_W-1:0] ir; logic [NCH-1:0] ta; logic [NCH-1:0] tna; } vec_t;
  vec_t vecs[5];

  int              c0, e, hold_end, next_start, push_at, pre;
  logic            do_pop, do_push, m_ovf, m_set;
  logic [SR_W-1:0] m_jdo, last_sr;
  logic [NCH-1:0]  exp_ta, exp_tna;
  cmd_entry_t      mq[$];
  cmd_entry_t      pend, ent;

  initial begin
    vecs[0] = '{38'h2A_5A5A_5A5A, 2'd2, 4'b0100, 4'b0000};
    vecs[1] = '{38'h05_1234_5678, 2'd1, 4'b0000, 4'b0010};
    vecs[2] = '{38'h08_0000_0001, 2'd0, 4'b0001, 4'b0000};
    vecs[3] = '{38'h37_FFFF_FFFF, 2'd3, 4'b0000, 4'b1000};
    vecs[4] = '{38'h3F_0000_0000, 2'd3, 4'b1000, 4'b0000};

    // Reset state
    tick(3);
    chk("rst_jdo", 64'(jdo), 64'd0);
    chk("rst_strobes", 64'({take_action, take_no_action}), 64'd0);
    chk("rst_uir", 64'(uir_pulse), 64'd0);
    chk("rst_pending", 64'(cmd_pending), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick(8);

    // Single-command vectors: latency, decode, jdo
    for (int i = 0; i < 5; i++) begin
      obs.delete();
      sr = vecs[i].sr; ir_in = vecs[i].ir; vs_udr = 1'b1; c0 = cyc;
      tick(10);
      vs_udr = 1'b0;
      tick(10);
      chk($sformatf("vec%0d_count", i), 64'(obs.size()), 64'd1);
      if (obs.size() > 0) begin
        chk($sformatf("vec%0d_latency", i), 64'(obs[0].c - c0), 64'(SYNC + 2));
        chk($sformatf("vec%0d_ta", i), 64'(obs[0].ta), 64'(vecs[i].ta));
        chk($sformatf("vec%0d_tna", i), 64'(obs[0].tna), 64'(vecs[i].tna));
      end
      chk($sformatf("vec%0d_jdo", i), 64'(jdo), 64'(vecs[i].sr));
    end

    // Backpressure with overflow
    cmd_ready = 1'b0; obs.delete();
    send(38'h08_0000_0011, 2'd0);
    send(38'h05_0000_0022, 2'd1);
    send(38'h3F_0000_0033, 2'd3);
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_pending", 64'(cmd_pending), 64'd1);
    chk("bp_no_strobe", 64'(obs.size()), 64'd0);
    cmd_ready = 1'b1;
    tick(6);
    chk("bp_count", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      chk("bp_first", 64'({obs[0].ta, obs[0].tna}), 64'({4'b0001, 4'b0000}));
      chk("bp_second", 64'({obs[1].ta, obs[1].tna}), 64'({4'b0000, 4'b0010}));
    end
    chk("bp_jdo", 64'(jdo), 64'(38'h05_0000_0022));
    chk("bp_ovf_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("bp_ovf_clr", 64'(overflow), 64'd0);

    // Full queue with push and pop on the same edge
    cmd_ready = 1'b0; obs.delete();
    send(38'h08_0000_00A1, 2'd0);
    send(38'h05_0000_00B2, 2'd1);
    chk("fp_pending", 64'(cmd_pending), 64'd1);
    sr = 38'h3F_0000_00C3; ir_in = 2'd2; vs_udr = 1'b1;
    tick(3);
    cmd_ready = 1'b1;
    tick(1);
    chk("fp_no_ovf_edge", 64'(overflow), 64'd0);
    tick(2);
    vs_udr = 1'b0;
    tick(6);
    chk("fp_no_ovf", 64'(overflow), 64'd0);
    chk("fp_count", 64'(obs.size()), 64'd3);
    if (obs.size() == 3) begin
      chk("fp_order0", 64'({obs[0].ta, obs[0].tna}), 64'({4'b0001, 4'b0000}));
      chk("fp_order1", 64'({obs[1].ta, obs[1].tna}), 64'({4'b0000, 4'b0010}));
      chk("fp_order2", 64'({obs[2].ta, obs[2].tna}), 64'({4'b0100, 4'b0000}));
    end
    chk("fp_jdo", 64'(jdo), 64'(38'h3F_0000_00C3));

    // Reset mid-operation with queued and in-flight commands
    cmd_ready = 1'b0;
    send(38'h08_0000_0D01, 2'd0);
    send(38'h05_0000_0D02, 2'd1);
    sr = 38'h08_0000_0D03; ir_in = 2'd3; vs_udr = 1'b1;
    tick(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_jdo", 64'(jdo), 64'd0);
    chk("mr_strobes", 64'({take_action, take_no_action}), 64'd0);
    chk("mr_pending", 64'(cmd_pending), 64'd0);
    chk("mr_overflow", 64'(overflow), 64'd0);
    chk("mr_uir", 64'(uir_pulse), 64'd0);
    tick(3);
    reset_n = 1'b1; cmd_ready = 1'b1; obs.delete();
    tick(20);
    chk("mr_no_strobe", 64'(obs.size()), 64'd0);
    chk("mr_no_pending", 64'(cmd_pending), 64'd0);
    vs_udr = 1'b0;
    tick(6);
    sr = 38'h2A_0000_0E0E; ir_in = 2'd1; vs_udr = 1'b1; c0 = cyc;
    tick(8);
    vs_udr = 1'b0;
    tick(6);
    chk("mr_rearm_count", 64'(obs.size()), 64'd1);
    if (obs.size() > 0) chk("mr_rearm_latency", 64'(obs[0].c - c0), 64'(SYNC + 2));
    chk("mr_rearm_jdo", 64'(jdo), 64'(38'h2A_0000_0E0E));
    last_sr = 38'h2A_0000_0E0E;

    // IR update strobe
    uir_obs.delete();
    vs_uir = 1'b1; c0 = cyc;
    tick(10);
    vs_uir = 1'b0;
    tick(6);
    chk("uir_count", 64'(uir_obs.size()), 64'd1);
    if (uir_obs.size() > 0) chk("uir_latency", 64'(uir_obs[0] - c0), 64'(SYNC + 1));

    // Randomized run against a queue model
    mq.delete(); m_ovf = 1'b0; m_jdo = last_sr; push_at = -1;
    next_start = cyc + 2; hold_end = 0;
    for (int t = 0; t < 1500; t++) begin
      e = cyc;
      if (!vs_udr && e >= next_start) begin
        sr = SR_W'({$urandom(), $urandom()});
        ir_in = IR_W'($urandom_range(0, 3));
        vs_udr = 1'b1;
        hold_end = e + int'($urandom_range(1, 6));
        next_start = hold_end + int'($urandom_range(4, 6));
        push_at = e + SYNC + 1;
        pend = '{sr, ir_in};
      end else if (vs_udr && e >= hold_end) begin
        vs_udr = 1'b0;
      end
      cmd_ready = ($urandom_range(0, 2) != 0);
      overflow_clr = ($urandom_range(0, 15) == 0);
      pre = mq.size();
      do_pop = (pre > 0) && cmd_ready;
      do_push = (push_at == e + 1);
      exp_ta = '0; exp_tna = '0; m_set = 1'b0;
      if (do_pop) begin
        ent = mq.pop_front();
        m_jdo = ent.sr;
        if (ent.sr[ACT_BIT]) exp_ta[ent.ir] = 1'b1;
        else exp_tna[ent.ir] = 1'b1;
      end
      if (do_push) begin
        if (pre == DEPTH && !do_pop) m_set = 1'b1;
        else mq.push_back(pend);
      end
      m_ovf = m_set ? 1'b1 : (overflow_clr ? 1'b0 : m_ovf);
      tick(1);
      chk("rnd_ta", 64'(take_action), 64'(exp_ta));
      chk("rnd_tna", 64'(take_no_action), 64'(exp_tna));
      chk("rnd_jdo", 64'(jdo), 64'(m_jdo));
      chk("rnd_overflow", 64'(overflow), 64'(m_ovf));
      chk("rnd_pending", 64'(cmd_pending), 64'(mq.size() != 0));
    end
    vs_udr = 1'b0; overflow_clr = 1'b0;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debug_cmd_sync.md
DEBUG_CMD_SYNC -- requirements
Module: debug_cmd_sync

Interface
REQ-001 SHALL have parameter SR_W, default 38: width of the JTAG data shift register and of jdo.
REQ-002 SHALL have parameter IR_W, default 2: instruction width; NCH = 2**IR_W action channels.
REQ-003 SHALL have parameter SYNC_STAGES, default 3, legal 2..4: synchroniser depth for vs_udr and vs_uir.
REQ-004 SHALL have parameter ACT_BIT, default SR_W-3: the jdo bit selecting action (1) or no-action (0).
REQ-005 SHALL have parameter CMD_DEPTH, default 2, power of two, 2..8: command queue depth.
REQ-006 SHALL have port clk, input, 1: system clock; the only clock.
REQ-007 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port sr, input, SR_W: JTAG shift register, quasi-static while vs_udr is high.
REQ-009 SHALL have port ir_in, input, IR_W: JTAG instruction, quasi-static after vs_uir.
REQ-010 SHALL have port vs_udr, input, 1: asynchronous update-DR level.
REQ-011 SHALL have port vs_uir, input, 1: asynchronous update-IR level.
REQ-012 SHALL have port cmd_ready, input, 1: consumer accepts a command this cycle.
REQ-013 SHALL have port overflow_clr, input, 1: clears the overflow flag.
REQ-014 SHALL have port jdo, output, SR_W: data of the last issued command.
REQ-015 SHALL have ports take_action and take_no_action, output, NCH each: one-cycle per-channel strobes.
REQ-016 SHALL have port uir_pulse, output, 1: one-cycle strobe on each synchronised vs_uir rising edge.
REQ-017 SHALL have ports cmd_pending (queue non-empty) and overflow (sticky), output, 1 each.

Function
REQ-018 SHALL pass vs_udr and vs_uir through SYNC_STAGES-flop chains, then a rising-edge detector; a level held high for any duration yields exactly one detection.
REQ-019 SHALL, on a vs_udr detection, push {sr, ir_in}, both sampled in the detection cycle, into the queue.
REQ-020 SHALL register uir_pulse from the vs_uir detection.
REQ-021 SHALL pop one entry per cycle when cmd_pending and cmd_ready are both 1, registering jdo <= entry.sr and raising exactly one strobe in the next cycle: take_action[entry.ir] if entry.sr[ACT_BIT] is 1, else take_no_action[entry.ir].
REQ-022 SHALL assert at most one of the 2*NCH strobes in any cycle; each strobe lasts exactly one cycle.
REQ-023 SHALL hold jdo between commands.
REQ-024 SHALL deliver the strobe SYNC_STAGES+2 clk edges after the first edge that samples vs_udr high, given an empty queue and cmd_ready high.
REQ-025 SHALL hold entries while cmd_ready is 0 and issue them in FIFO order.
REQ-026 SHALL allow a simultaneous push and pop when the queue is full; this is not an overflow.
REQ-027 SHALL, on a push to a full queue without a pop, drop the new entry, keep queued entries intact, and set overflow.
REQ-028 SHALL clear overflow on overflow_clr; a coincident new overflow wins and leaves it set.

Reset
REQ-029 SHALL, on reset_n low at any time, immediately clear the sync chains, edge registers, queue pointers and count, jdo, all strobes, uir_pulse, cmd_pending and overflow to 0.
REQ-030 SHALL discard in-flight and queued commands on reset, with no strobe issued afterwards for them.
REQ-031 SHALL not issue a detection after reset release for a vs_udr that is already high at release, until vs_udr falls and rises again.

Structure
REQ-032 SHALL take parameter defaults and the queue entry type {sr, ir} from shared package debug_cmd_pkg.
REQ-033 SHALL implement the queue as sub-module debug_cmd_fifo (parametrised width/depth; push, pop, full, empty; async reset).

Verification
REQ-034 SHALL cover single command: SYNC_STAGES=3, ir_in=2, sr[ACT_BIT]=1, sr=0x2A_5A5A_5A5A, vs_udr high 10 cycles -> one take_action[2] pulse 5 edges later, jdo=sr, no other strobe.
REQ-035 SHALL cover no-action decode: ir_in=1, sr[ACT_BIT]=0 -> one take_no_action[1] pulse only.
REQ-036 SHALL cover backpressure: cmd_ready=0, three commands (ir 0,1,3), CMD_DEPTH=2 -> overflow=1, cmd_pending=1; after cmd_ready=1, strobes on channel 0 then 1 only; overflow_clr -> overflow=0.
REQ-037 SHALL cover full with simultaneous push/pop: queue full, pop and push in one cycle -> overflow stays 0, order preserved.
REQ-038 SHALL cover mid-operation reset: reset_n pulsed low with two queued commands -> all outputs 0 at once, no strobe after release with vs_udr held high.
REQ-039 SHALL cover IR update: vs_uir rising -> uir_pulse exactly one cycle, SYNC_STAGES+1 edges later.
